spike_raster_fifo: RTL and testbench
====================================

Name: spike_raster_fifo

Overview:
- Downstream consumer of the integrate-and-fire network's output spike vector.
- On every enabled timestep with at least one output spike, pushes one entry {timestep, spike vector} into an on-chip FIFO.
- Host software drains the FIFO through the AXI config-register block to reconstruct the output spike raster. This complements the aggregate spike counters with timing information.
- Sits beside the spike counter, fed by network spike_out, spike_en and the sim-time counter.

Parameters:
- NUM_OUTPUTS, 1, width of spike vector; legal range 1..24.
- DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 entries.
- DROP_CNT_BITS, 16, width of the saturating dropped-entry counter.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear, driven by the network reset (ctrl[0] or reset).
- spike_valid  in  1  timestep-enable strobe (spike_en).
- timestep  in  32  current sim-time counter value.
- spike_in  in  NUM_OUTPUTS  output spike vector for this cycle.
- rd_en  in  1  single-cycle pop strobe from the register block.
- rd_data  out  32  head entry, first-word-fall-through.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  number of stored entries.
- overflow  out  1  sticky; set when an entry is dropped.
- dropped_count  out  DROP_CNT_BITS  saturating count of dropped entries.

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous):
  - wr_ptr, rd_ptr, count, overflow and dropped_count go to 0.
  - empty=1, full=0, rd_data=0.
  - Storage contents are don't-care.
- clr (synchronous, highest priority after reset):
  - Same clearing effect as reset on the next rising edge.
  - A push or pop in the same cycle is discarded.
- Entry format:
  - bits [NUM_OUTPUTS-1:0] = spike_in.
  - bits [31:NUM_OUTPUTS] = timestep[31-NUM_OUTPUTS:0] (truncated; wraps modulo 2**(32-NUM_OUTPUTS)).
- Push request: spike_valid=1 and spike_in != 0. An all-zero vector never creates an entry.
- Push accepted when not full, or when full with an accepted pop in the same cycle.
  - Entry is written at wr_ptr; wr_ptr increments modulo depth.
- Push rejected when full and no pop:
  - overflow set to 1 (sticky until reset/clr).
  - dropped_count increments and saturates at all-ones.
- Pop accepted when rd_en=1 and not empty. rd_ptr increments. rd_en while empty is ignored; no state change.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - When empty, only the push is accepted; there is no bypass of the pushed entry to rd_data in that cycle.
- rd_data:
  - Combinationally reflects storage[rd_ptr] when not empty; 0 when empty.
  - A newly pushed entry is visible on rd_data the cycle after the push edge.
- count, empty and full are registered and consistent with each other every cycle.
  - empty = (count==0); full = (count==2**DEPTH_LOG2).
- Throughput: one push and one pop per cycle maximum. Latency from push to visibility is 1 cycle.

Decomposition:
- snn_pkg:
  - SPIKE_RASTER_ENTRY_W = 32.
  - A localparam function giving the timestep field width (32-NUM_OUTPUTS).
  - A typedef for the packed entry struct {timestep_field, spikes}, parameterised via NUM_OUTPUTS.
- One natural sub-module, sync_fifo_core (generic storage + pointers + count, FWFT). spike_raster_fifo adds:
  - entry packing;
  - the push-qualification logic;
  - the overflow and drop-count logic.

Test Plan:
- Reset then idle: hold spike_in=0, spike_valid=1 for 20 cycles -> empty=1, count=0, rd_data=0, overflow=0.
- Single entry: NUM_OUTPUTS=4, timestep=7, spike_in=4'b1010, spike_valid=1 for one cycle -> next cycle count=1, rd_data=32'h0000007A. Pulse rd_en -> empty=1 next cycle.
- Fill and overflow: DEPTH_LOG2=2, push 6 nonzero vectors on consecutive cycles with no pops:
  - full=1 after the 4th push; overflow=1, dropped_count=2.
  - Draining returns the first 4 entries in order.
- Full with simultaneous push+pop: FIFO full, rd_en=1 and a valid push in the same cycle -> count stays 4, overflow unchanged, the new entry appears last on drain.
- Empty pop and push/pop on empty: rd_en while empty -> no change. Push with rd_en in the same cycle on an empty FIFO -> count=1 and the entry is retained.
- clr mid-operation: 3 entries stored, overflow=1; assert clr with a concurrent push -> next cycle count=0, empty=1, overflow=0, dropped_count=0. The concurrent push is discarded.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared widths and helpers for the spike-network datapath blocks.
package snn_pkg;
  localparam int SPIKE_RASTER_ENTRY_W = 32;
  function automatic int ts_field_w(input int num_outputs);
    return SPIKE_RASTER_ENTRY_W - num_outputs;
  endfunction
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: first-word-fall-through FIFO with registered count/empty/full.
module sync_fifo_core #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [W-1:0]          wdata_i,
  output logic                  push_ok_o,
  output logic [W-1:0]          rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);
  logic [W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic empty_q, full_q, pop_ok;
  always_comb begin
    pop_ok    = pop_i && !empty_q;
    push_ok_o = push_i && (!full_q || pop_ok);
    wr_ptr_d  = clr_i ? '0 : wr_ptr_q + DEPTH_LOG2'(push_ok_o);
    rd_ptr_d  = clr_i ? '0 : rd_ptr_q + DEPTH_LOG2'(pop_ok);
    count_d   = clr_i ? '0 : count_q + CW'(push_ok_o) - CW'(pop_ok);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= count_d == '0;
      full_q   <= count_d == DEPTH;
    end
  end
  // storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push_ok_o && !clr_i) mem[wr_ptr_q] <= wdata_i;
  end
  assign rdata_o = empty_q ? '0 : mem[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign count_o = count_q;
endmodule

// File: rtl/spike_raster_fifo.sv
// spike_raster_fifo: logs {timestep, spike vector} for every timestep with output spikes.
module spike_raster_fifo
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS   = 1,
  parameter int DEPTH_LOG2    = 6,
  parameter int DROP_CNT_BITS = 16
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     clr,
  input  logic                     spike_valid,
  input  logic [31:0]              timestep,
  input  logic [NUM_OUTPUTS-1:0]   spike_in,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [DEPTH_LOG2:0]      count,
  output logic                     overflow,
  output logic [DROP_CNT_BITS-1:0] dropped_count
);
  localparam int TSW = ts_field_w(NUM_OUTPUTS);
  typedef struct packed {
    logic [TSW-1:0]         ts;
    logic [NUM_OUTPUTS-1:0] spikes;
  } entry_t;
  entry_t entry;
  logic push_req, push_ok, drop, unused_ts;
  logic overflow_q, overflow_d;
  logic [DROP_CNT_BITS-1:0] dropped_q, dropped_d;
  assign unused_ts = ^timestep[31:TSW];
  always_comb begin
    entry.ts     = timestep[TSW-1:0];
    entry.spikes = spike_in;
    push_req     = spike_valid && |spike_in;
    drop         = push_req && !push_ok && !clr;
    overflow_d   = clr ? 1'b0 : overflow_q | drop;
    dropped_d    = clr ? '0 : (drop && !(&dropped_q)) ? dropped_q + 1'b1 : dropped_q;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end
  sync_fifo_core #(.W(SPIKE_RASTER_ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_core (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .clr_i     (clr),
    .push_i    (push_req),
    .pop_i     (rd_en),
    .wdata_i   (entry),
    .push_ok_o (push_ok),
    .rdata_o   (rd_data),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count)
  );
  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;
endmodule

// File: tb/tb_spike_raster_fifo.sv
// tb_spike_raster_fifo: directed stimulus checked against a queue model every cycle.
module tb_spike_raster_fifo;
  logic clk = 0, rst_n = 0, clr = 0, spike_valid = 0, rd_en = 0;
  logic [31:0] timestep = 0;
  logic [3:0] spike_in = 0;
  logic [31:0] rd_data;
  logic empty, full, overflow;
  logic [2:0] count;
  logic [15:0] dropped_count;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_q[$];
  logic m_ovf = 0;
  int m_drop = 0, m_sz;
  bit m_pop, m_push, run_cmp = 0;

  spike_raster_fifo #(.NUM_OUTPUTS(4), .DEPTH_LOG2(2), .DROP_CNT_BITS(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .clr(clr), .spike_valid(spike_valid),
    .timestep(timestep), .spike_in(spike_in), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ent(input logic [31:0] ts, input logic [3:0] sp);
    return {ts[27:0], sp};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_q.delete();
      m_ovf = 0;
      m_drop = 0;
    end else begin
      m_sz = m_q.size();
      m_pop = rd_en && m_sz > 0;
      m_push = spike_valid && spike_in != 0;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_sz < 4 || m_pop) m_q.push_back(ent(timestep, spike_in));
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  always @(negedge clk) if (run_cmp) begin
    chk("m_count", 32'(count), 32'(m_q.size()));
    chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
    chk("m_full", 32'(full), 32'(m_q.size() == 4));
    chk("m_rd_data", rd_data, m_q.size() > 0 ? m_q[0] : 32'h0);
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_dropped", 32'(dropped_count), 32'(m_drop));
  end

  task automatic step(input logic sv, input logic [31:0] ts, input logic [3:0] sp,
                      input logic rd, input logic cl);
    spike_valid = sv; timestep = ts; spike_in = sp; rd_en = rd; clr = cl;
    @(negedge clk);
    spike_valid = 0; spike_in = 0; rd_en = 0; clr = 0;
  endtask

  initial begin
    run_cmp = 1;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) step(1, 32'(i), 4'h0, 0, 0);
    chk("idle_empty", 32'(empty), 1);
    chk("idle_count", 32'(count), 0);
    chk("idle_rd_data", rd_data, 0);
    chk("idle_overflow", 32'(overflow), 0);
    step(1, 7, 4'b1010, 0, 0);
    chk("single_count", 32'(count), 1);
    chk("single_rd_data", rd_data, 32'h0000007A);
    step(0, 0, 4'h0, 1, 0);
    chk("single_pop_empty", 32'(empty), 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 32'(100 + i), 4'(i + 1), 0, 0);
      if (i == 3) chk("fill_full", 32'(full), 1);
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_dropped", 32'(dropped_count), 2);
    chk("ovf_first", rd_data, 32'h00000641);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", rd_data, ent(32'(100 + i), 4'(i + 1)));
      step(0, 0, 4'h0, 1, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    for (int i = 0; i < 4; i++) step(1, 32'(500 + i), 4'(i + 1), 0, 0);
    step(1, 600, 4'hF, 1, 0);
    chk("pp_full_count", 32'(count), 4);
    chk("pp_full_ovf", 32'(overflow), 1);
    chk("pp_full_dropped", 32'(dropped_count), 2);
    for (int i = 1; i < 4; i++) begin
      chk("pp_drain", rd_data, ent(32'(500 + i), 4'(i + 1)));
      step(0, 0, 4'h0, 1, 0);
    end
    chk("pp_last", rd_data, 32'h00000258F);
    step(0, 0, 4'h0, 1, 0);
    step(0, 0, 4'h0, 1, 0);
    chk("empty_pop_count", 32'(count), 0);
    chk("empty_pop_rd", rd_data, 0);
    step(1, 300, 4'h3, 1, 0);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_rd", rd_data, 32'h000012C3);
    step(0, 0, 4'h0, 1, 0);
    step(1, 32'hFFFF_FFF0, 4'h1, 0, 0);
    chk("ts_wrap", rd_data, 32'hFFFFFF01);
    step(1, 1, 4'h2, 0, 0);
    step(1, 2, 4'h4, 0, 0);
    step(1, 3, 4'h8, 0, 0);
    step(1, 4, 4'h8, 0, 0);
    chk("pre_clr_ovf", 32'(overflow), 1);
    chk("pre_clr_full", 32'(full), 1);
    step(1, 400, 4'h5, 0, 1);
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_dropped", 32'(dropped_count), 0);
    step(0, 0, 4'h0, 0, 0);
    chk("clr_push_discarded", 32'(empty), 1);
    run_cmp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
